// File: rtl/vram_scan_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : vram_scan_arbiter_if
// Description : Writer request/acknowledge bus into the VRAM scan arbiter.
// Revision    : 1.0  initial release
// ============================================================================
interface vram_scan_arbiter_if #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 12
) ();
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ack;
    logic              wr_oob;

    // master = game-logic writer, slave = arbiter
    modport master (
        output wr_req,
        output wr_addr,
        output wr_data,
        input  wr_ack,
        input  wr_oob
    );

    modport slave (
        input  wr_req,
        input  wr_addr,
        input  wr_data,
        output wr_ack,
        output wr_oob
    );
endinterface
`default_nettype wire

// File: rtl/vram_scan_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : vram_scan_arbiter
// Description : Single-port VRAM owner; display scan-out reads win on visible
//               pixel ticks, writer gets the remaining slots.
// Revision    : 1.0  initial release
// ============================================================================
module vram_scan_arbiter #(
    parameter int H_VISIBLE = 640,
    parameter int V_VISIBLE = 480,
    parameter int FB_W      = 160,
    parameter int FB_H      = 120,
    parameter int ADDR_W    = 15,
    parameter int DATA_W    = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pix_tick,
    input  logic [9:0]            hcount,
    input  logic [9:0]            vcount,
    vram_scan_arbiter_if.slave    wr,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic                  mem_we,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic [DATA_W-1:0]     rgb,
    output logic                  frame_tick
);

    localparam logic [ADDR_W-1:0] c_fb_w    = ADDR_W'(FB_W);
    localparam logic [ADDR_W-1:0] c_fb_size = ADDR_W'(FB_W * FB_H);
    localparam logic [9:0]        c_h_vis   = 10'(H_VISIBLE);
    localparam logic [9:0]        c_v_vis   = 10'(V_VISIBLE);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DISP  = 2'd1,
        S_WRITE = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              w_issue_disp;
    logic              w_issue_wr;
    logic              w_active;
    logic              w_disp;
    logic              w_wr_ok;
    logic              w_wr_in_range;
    logic [ADDR_W-1:0] w_disp_addr;

    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_mem_we;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_wr_ack;
    logic              r_wr_oob;
    logic [DATA_W-1:0] r_rgb;
    logic              r_frame_tick;
    logic              r_rd_valid;
    logic              r_rd_blank;

    assign w_active      = (hcount < c_h_vis) && (vcount < c_v_vis);
    assign w_disp        = pix_tick && w_active;
    assign w_disp_addr   = ADDR_W'(vcount >> 2) * c_fb_w + ADDR_W'(hcount >> 2);
    assign w_wr_in_range = wr.wr_addr < c_fb_size;
    // The cycle with wr_ack high is the writer's mandatory gap, so a held
    // request can be granted again from HOLD, giving one write per 2 clks.
    assign w_wr_ok       = wr.wr_req && !r_wr_ack;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = S_IDLE;
        w_issue_disp = 1'b0;
        w_issue_wr   = 1'b0;
        if (w_disp) begin
            w_next       = S_DISP;
            w_issue_disp = 1'b1;
        end else if (r_state == S_WRITE) begin
            w_next = S_HOLD;
        end else if (w_wr_ok) begin
            w_next     = S_WRITE;
            w_issue_wr = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mem_addr   <= '0;
            r_mem_we     <= 1'b0;
            r_mem_wdata  <= '0;
            r_wr_ack     <= 1'b0;
            r_wr_oob     <= 1'b0;
            r_rgb        <= '0;
            r_frame_tick <= 1'b0;
            r_rd_valid   <= 1'b0;
            r_rd_blank   <= 1'b0;
        end else begin
            r_wr_ack     <= w_issue_wr;
            r_mem_we     <= w_issue_wr && w_wr_in_range;
            r_frame_tick <= pix_tick && (vcount == c_v_vis) && (hcount == '0);

            if (w_issue_disp) begin
                r_mem_addr <= w_disp_addr;
            end else if (w_issue_wr) begin
                r_mem_addr  <= wr.wr_addr;
                r_mem_wdata <= wr.wr_data;
            end

            if (w_issue_wr && !w_wr_in_range) begin
                r_wr_oob <= 1'b1;
            end

            // Blank ticks run through the same two-stage pipe so rgb goes
            // to black with the same latency as a visible pixel.
            r_rd_valid <= pix_tick;
            r_rd_blank <= !w_active;
            if (r_rd_valid) begin
                r_rgb <= r_rd_blank ? '0 : mem_rdata;
            end
        end
    end

    assign mem_addr   = r_mem_addr;
    assign mem_we     = r_mem_we;
    assign mem_wdata  = r_mem_wdata;
    assign rgb        = r_rgb;
    assign frame_tick = r_frame_tick;
    assign wr.wr_ack  = r_wr_ack;
    assign wr.wr_oob  = r_wr_oob;

endmodule
`default_nettype wire

// File: tb/tb_vram_scan_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_vram_scan_arbiter
// Description : Scoreboard bench for vram_scan_arbiter with a VRAM model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_vram_scan_arbiter;
    localparam int ADDR_W = 15;
    localparam int DATA_W = 12;

    logic              clk      = 1'b0;
    logic              reset    = 1'b1;
    logic              pix_tick = 1'b0;
    logic [9:0]        hcount   = '0;
    logic [9:0]        vcount   = '0;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] rgb;
    logic              frame_tick;

    int   cyc      = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    logic tb_oob   = 1'b0;

    // VRAM model: untouched words hold the low 12 bits of their address
    logic [DATA_W-1:0] vram    [0:32767];
    bit                written [0:32767];

    typedef struct { int cyc; logic [ADDR_W-1:0] addr; } aexp_t;
    typedef struct { int cyc; logic [DATA_W-1:0] rgb; } rexp_t;
    typedef struct { logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] data; logic we; logic oob; } wexp_t;
    aexp_t aq[$];
    rexp_t rq[$];
    wexp_t wq[$];
    int    fq[$];

    vram_scan_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) wr_if ();

    vram_scan_arbiter #(
        .H_VISIBLE(640), .V_VISIBLE(480), .FB_W(160), .FB_H(120),
        .ADDR_W(ADDR_W), .DATA_W(DATA_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .pix_tick  (pix_tick),
        .hcount    (hcount),
        .vcount    (vcount),
        .wr        (wr_if.slave),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .rgb       (rgb),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (mem_we) begin
            vram[mem_addr]    <= mem_wdata;
            written[mem_addr] <= 1'b1;
        end
    end

    assign mem_rdata = written[mem_addr] ? vram[mem_addr] : mem_addr[11:0];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [ADDR_W-1:0] fb_addr(input int h, input int v);
        return ADDR_W'((v / 4) * 160 + (h / 4));
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_disp(input int h, input int v);
        logic [ADDR_W-1:0] a;
        if (h < 640 && v < 480) begin
            a = fb_addr(h, v);
            aq.push_back('{cyc + 1, a});
            rq.push_back('{cyc + 2, a[11:0]});
        end else begin
            rq.push_back('{cyc + 2, 12'h000});
        end
        if (v == 480 && h == 0) fq.push_back(cyc + 1);
    endtask

    task automatic push_wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        logic we;
        we = (a < 15'd19200);
        if (!we) tb_oob = 1'b1;
        wq.push_back('{a, d, we, tb_oob});
    endtask

    task automatic disp_tick(input int h, input int v);
        pix_tick = 1'b1;
        hcount   = 10'(h);
        vcount   = 10'(v);
        push_disp(h, v);
        idle(1);
        pix_tick = 1'b0;
        idle(3);
    endtask

    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, output int ack_cyc);
        wr_if.wr_req  = 1'b1;
        wr_if.wr_addr = a;
        wr_if.wr_data = d;
        push_wr(a, d);
        ack_cyc = -1;
        for (int i = 0; i < 20; i++) begin
            idle(1);
            if (wr_if.wr_ack) begin
                ack_cyc = cyc;
                break;
            end
        end
        if (ack_cyc < 0) check_val("wr_timeout", 64'd0, 64'd1);
    endtask

    task automatic check_reset_outs(input string tag);
        check_val(tag, {mem_addr, mem_we, mem_wdata, wr_if.wr_ack, wr_if.wr_oob, rgb, frame_tick}, 64'd0);
    endtask

    always @(negedge clk) begin
        logic fexp;
        if (aq.size() > 0 && aq[0].cyc == cyc) begin
            check_val("disp_addr", mem_addr, aq[0].addr);
            check_val("disp_we", mem_we, 64'd0);
            aq.delete(0);
        end
        if (rq.size() > 0 && rq[0].cyc == cyc) begin
            check_val("rgb", rgb, rq[0].rgb);
            rq.delete(0);
        end
        fexp = (fq.size() > 0 && fq[0] == cyc);
        if (fexp || frame_tick === 1'b1) begin
            check_val("frame_tick", frame_tick, fexp);
            if (fexp) fq.delete(0);
        end
        if (wr_if.wr_ack === 1'b1) begin
            if (wq.size() == 0) begin
                check_val("wr_unexpected_ack", 64'd1, 64'd0);
            end else begin
                check_val("wr_addr", mem_addr, wq[0].addr);
                check_val("wr_we", mem_we, wq[0].we);
                check_val("wr_data", mem_wdata, wq[0].data);
                check_val("wr_oob", wr_if.wr_oob, wq[0].oob);
                wq.delete(0);
            end
        end
        if (mem_we === 1'b1) check_val("we_without_ack", wr_if.wr_ack, 64'd1);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish by time limit");
        $fatal(1);
    end

    initial begin
        int a0, a1, a2, ac, c;
        wr_if.wr_req  = 1'b0;
        wr_if.wr_addr = '0;
        wr_if.wr_data = '0;

        idle(3);
        check_reset_outs("reset_outs");
        reset = 1'b0;
        idle(2);

        // scan-out reads, blanking and frame tick
        disp_tick(8, 4);
        disp_tick(100, 200);
        disp_tick(639, 479);
        disp_tick(640, 10);
        disp_tick(0, 480);
        disp_tick(4, 480);
        disp_tick(0, 481);
        disp_tick(20, 8);
        disp_tick(700, 300);

        // back-to-back writes in vblank
        vcount = 10'd490;
        do_write(15'd5, 12'hF00, a0);
        do_write(15'd6, 12'h0F0, a1);
        do_write(15'd7, 12'h00F, a2);
        wr_if.wr_req = 1'b0;
        check_val("b2b_gap1", a1 - a0, 64'd2);
        check_val("b2b_gap2", a2 - a1, 64'd2);
        idle(2);
        check_val("vram5", vram[5], 12'hF00);

        // collisions: display read first, then the write
        for (int i = 0; i < 100; i++) begin
            int h, v;
            h = $urandom_range(0, 639);
            v = $urandom_range(4, 479);
            pix_tick      = 1'b1;
            hcount        = 10'(h);
            vcount        = 10'(v);
            wr_if.wr_req  = 1'b1;
            wr_if.wr_addr = 15'($urandom_range(0, 159));
            wr_if.wr_data = 12'($urandom);
            push_disp(h, v);
            push_wr(wr_if.wr_addr, wr_if.wr_data);
            idle(1);
            pix_tick = 1'b0;
            check_val("coll_no_ack", wr_if.wr_ack, 64'd0);
            idle(1);
            check_val("coll_ack", wr_if.wr_ack, 64'd1);
            wr_if.wr_req = 1'b0;
            idle(2);
        end

        // out-of-range write and sticky flag
        vcount = 10'd500;
        do_write(15'd19200, 12'hABC, ac);
        wr_if.wr_req = 1'b0;
        idle(2);
        do_write(15'd30, 12'h123, ac);
        wr_if.wr_req = 1'b0;
        idle(3);
        check_val("oob_sticky", wr_if.wr_oob, 64'd1);

        // reset right after a granted write
        do_write(15'd40, 12'h456, ac);
        wr_if.wr_req = 1'b0;
        reset        = 1'b1;
        idle(1);
        check_reset_outs("reset_after_write");
        tb_oob = 1'b0;
        reset  = 1'b0;
        idle(2);

        // reset mid-line kills an in-flight read
        disp_tick(40, 40);
        c        = cyc;
        pix_tick = 1'b1;
        hcount   = 10'd80;
        vcount   = 10'd40;
        idle(1);
        pix_tick = 1'b0;
        reset    = 1'b1;
        idle(1);
        check_val("reset_mid_cyc", cyc - c, 64'd2);
        check_reset_outs("reset_midline");
        reset = 1'b0;
        idle(3);
        disp_tick(44, 40);
        disp_tick(640, 40);
        disp_tick(600, 476);

        idle(4);
        check_val("q_addr_empty", aq.size(), 64'd0);
        check_val("q_rgb_empty", rq.size(), 64'd0);
        check_val("q_wr_empty", wq.size(), 64'd0);
        check_val("q_frame_empty", fq.size(), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
